// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared definitions for the keypad entry front-end: key codes, FSM states and
// the command mode.
package keypad_entry_ctrl_pkg;

  localparam logic [3:0] KEY_SET       = 4'hA;
  localparam logic [3:0] KEY_LOGIN     = 4'hB;
  localparam logic [3:0] KEY_CANCEL    = 4'hE;
  localparam logic [3:0] KEY_ENTER     = 4'hF;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_DIGIT = 3'd1,
    ST_WAIT_ENTER = 3'd2,
    ST_ISSUE      = 3'd3,
    ST_GAP        = 3'd4
  } entry_state_e;

  typedef enum logic {
    MODE_SET   = 1'b0,
    MODE_LOGIN = 1'b1
  } entry_mode_e;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= KEY_DIGIT_MAX;
  endfunction

  function automatic logic is_mode(input logic [3:0] k);
    return (k == KEY_SET) || (k == KEY_LOGIN);
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_key_debounce.sv
// Keypad debouncer: one key_evt per accepted press, re-armed only after the
// keypad has been released for DEBOUNCE_CYC consecutive cycles.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw_valid,
  input  logic [3:0] key_raw,
  output logic       key_evt,
  output logic [3:0] key_code
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

  logic          prev_valid;
  logic [3:0]    prev_code;
  logic [CW-1:0] press_cnt;
  logic [CW-1:0] rel_cnt;
  logic          locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_code  <= 4'h0;
      press_cnt  <= '0;
      rel_cnt    <= '0;
      locked     <= 1'b0;
      key_evt    <= 1'b0;
      key_code   <= 4'h0;
    end else begin
      prev_valid <= key_raw_valid;
      prev_code  <= key_raw;

      // press_cnt = length of the current run of one valid code, saturating
      if (!key_raw_valid) begin
        press_cnt <= '0;
      end else if (!prev_valid || (key_raw != prev_code)) begin
        press_cnt <= CW'(1);
      end else if (press_cnt != CNT_MAX) begin
        press_cnt <= press_cnt + CW'(1);
      end

      if (key_raw_valid) begin
        rel_cnt <= '0;
      end else if (rel_cnt != CNT_MAX) begin
        rel_cnt <= rel_cnt + CW'(1);
      end

      key_evt <= 1'b0;
      if (locked) begin
        if (rel_cnt == CNT_MAX) begin
          locked <= 1'b0;
        end
      end else if (press_cnt == CNT_MAX) begin
        key_evt  <= 1'b1;
        key_code <= prev_code;
        locked   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry parser: turns debounced [mode, digit, enter] sequences into
// one-cycle set_pin/login commands followed by a quiet gap.
module keypad_entry_ctrl
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int CMD_GAP      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw_valid,
  input  logic [3:0] key_raw,
  output logic [3:0] pin,
  output logic [3:0] login_pin,
  output logic       set_pin,
  output logic       login,
  output logic       busy,
  output logic       entry_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(CMD_GAP + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(CMD_GAP - 1);

  logic       key_evt;
  logic [3:0] key_code;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_deb (
    .clk          (clk),
    .rst          (rst),
    .key_raw_valid(key_raw_valid),
    .key_raw      (key_raw),
    .key_evt      (key_evt),
    .key_code     (key_code)
  );

  entry_state_e  state, state_n;
  entry_mode_e   mode, mode_n;
  logic [3:0]    digit, digit_n;
  logic [TW-1:0] timer, timer_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          err_n, set_n, login_n;

  always_comb begin
    state_n = state;
    mode_n  = mode;
    digit_n = digit;
    timer_n = timer;
    gap_n   = gap_cnt;
    err_n   = 1'b0;
    set_n   = 1'b0;
    login_n = 1'b0;
    case (state)
      ST_IDLE: begin
        if (key_evt && is_mode(key_code)) begin
          mode_n  = (key_code == KEY_SET) ? MODE_SET : MODE_LOGIN;
          state_n = ST_WAIT_DIGIT;
          timer_n = '0;
        end
      end
      ST_WAIT_DIGIT, ST_WAIT_ENTER: begin
        if (key_evt) begin
          timer_n = '0;
          if (is_digit(key_code)) begin
            digit_n = key_code;
            state_n = ST_WAIT_ENTER;
          end else if (is_mode(key_code)) begin
            mode_n  = (key_code == KEY_SET) ? MODE_SET : MODE_LOGIN;
            state_n = ST_WAIT_DIGIT;
          end else if (key_code == KEY_CANCEL) begin
            state_n = ST_IDLE;
          end else if (key_code == KEY_ENTER) begin
            // enter with no digit yet is an illegal sequence
            if (state == ST_WAIT_DIGIT) begin
              err_n   = 1'b1;
              state_n = ST_IDLE;
            end else begin
              state_n = ST_ISSUE;
              set_n   = (mode == MODE_SET);
              login_n = (mode == MODE_LOGIN);
            end
          end
        end else if (timer == TIMER_LAST) begin
          err_n   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      ST_ISSUE: begin
        state_n = ST_GAP;
        gap_n   = '0;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = ST_IDLE;
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the pulse and its code
  // become visible together during the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode      <= MODE_SET;
      digit     <= 4'h0;
      timer     <= '0;
      gap_cnt   <= '0;
      pin       <= 4'h0;
      login_pin <= 4'h0;
      set_pin   <= 1'b0;
      login     <= 1'b0;
      entry_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      digit     <= digit_n;
      timer     <= timer_n;
      gap_cnt   <= gap_n;
      set_pin   <= set_n;
      login     <= login_n;
      entry_err <= err_n;
      busy      <= (state_n != ST_IDLE);
      if (set_n) begin
        pin <= digit;
      end
      if (login_n) begin
        login_pin <= digit;
      end
    end
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Front-end stage that sits directly upstream of the digital lock controller.
- Debounces a raw keypad, parses the key sequence [mode key, digit, enter] and issues lock commands.
- Each command is a one-cycle set_pin or login pulse, with the 4-bit code held stable on pin or login_pin.
- Enforces a quiet gap after each command so the downstream lock FSM can finish its SET_PIN/LOGIN/ALERT sequence.

Parameters:
- DEBOUNCE_CYC, 16, consecutive stable cycles required to accept a key press or a key release.
- TIMEOUT_CYC, 1000, idle cycles allowed between key events mid-entry before the entry is aborted.
- CMD_GAP, 8, cycles after a command pulse during which new key events are dropped.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- key_raw_valid  in  1  keypad reports a key held (raw level, may bounce).
- key_raw  in  4  raw key code: 0x0-0x9 digit, 0xA SET mode, 0xB LOGIN mode, 0xC/0xD unused, 0xE cancel, 0xF enter.
- pin  out  4  code for the set command; held until the next set command.
- login_pin  out  4  code for the login command; held until the next login command.
- set_pin  out  1  one-cycle set command pulse.
- login  out  1  one-cycle login command pulse.
- busy  out  1  high in every state except IDLE.
- entry_err  out  1  one-cycle pulse when an entry is aborted by timeout or illegal sequence.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, debouncer disarmed with counts cleared. Reset mid-entry discards any partial entry.
- All outputs are registered.
- Debounce:
  - A counter runs while key_raw_valid=1 and key_raw equals the code sampled last cycle. A code change or a valid drop clears it.
  - When the count reaches DEBOUNCE_CYC, emit a one-cycle key_evt carrying the code on the next cycle.
  - After that, no further event fires until key_raw_valid has stayed low for DEBOUNCE_CYC consecutive cycles. Holding a key never repeats.
  - The counter saturates and does not wrap.
- FSM states: IDLE, WAIT_DIGIT, WAIT_ENTER, ISSUE, GAP. The mode bit (set or login) and the 4-bit digit are kept internally.
- IDLE:
  - 0xA or 0xB: latch mode -> WAIT_DIGIT.
  - Every other key is ignored with no error.
- WAIT_DIGIT:
  - Digit: latch it -> WAIT_ENTER.
  - 0xA/0xB: relatch mode, stay.
  - 0xE: -> IDLE, no error.
  - 0xF: entry_err, -> IDLE.
  - 0xC/0xD: ignored.
- WAIT_ENTER:
  - Digit: overwrite the latched digit (last one wins).
  - 0xA/0xB: relatch mode -> WAIT_DIGIT.
  - 0xE: -> IDLE.
  - 0xF: -> ISSUE.
- Timeout: a timer counts cycles without a key_evt in WAIT_DIGIT and WAIT_ENTER, and clears on every key_evt and on state entry. When it reaches TIMEOUT_CYC: entry_err pulse, -> IDLE.
- ISSUE (exactly 1 cycle):
  - Set mode: pin <= digit and set_pin=1 in the same cycle.
  - Login mode: login_pin <= digit and login=1.
  - The other code output is unchanged. -> GAP.
- Latency: the command pulse appears 1 cycle after the enter key_evt cycle.
- GAP:
  - Lasts CMD_GAP cycles; key_evt is dropped.
  - The debouncer keeps running, so a key held across the gap does not fire on exit.
  - -> IDLE.
- The code outputs stay stable for at least CMD_GAP+1 cycles after a pulse, which covers the downstream capture delay.
- Only one of set_pin/login is ever high, and never twice within CMD_GAP+1 cycles.

Decomposition:
- Shared package holds:
  - key code constants: KEY_SET=4'hA, KEY_LOGIN=4'hB, KEY_CANCEL=4'hE, KEY_ENTER=4'hF, plus the digit range limit 4'h9;
  - the FSM state encoding (3 bits);
  - the mode encoding.
- One sub-module, key_debounce: clk, rst, key_raw_valid, key_raw in; key_evt and key_code out; parameter DEBOUNCE_CYC.
- The parser, timeout timer and command issue logic stay in keypad_entry_ctrl.

Test Plan (DEBOUNCE_CYC=4, TIMEOUT_CYC=50, CMD_GAP=8):
- Clean set entry: A, 7, F, each held 6 cycles with 6-cycle releases -> set_pin high exactly 1 cycle, 1 cycle after the F event; pin=4'h7 held; login stays 0; busy=0 again 9 cycles after the pulse.
- Bounce rejection: key 0x3 toggles valid every 2 cycles for 20 cycles, then is held 5 cycles -> exactly one key_evt; a login entry (B, bounced 3, F) yields login_pin=4'h3 with one login pulse.
- Last digit wins and cancel: B, 2, 5, F -> login_pin=4'h5. Then A, 9, E -> no pulse, pin unchanged, busy=0.
- Timeout and illegal sequence:
  - B, 4, then no keys for 50 cycles -> entry_err 1-cycle pulse, IDLE, no login.
  - A, F -> entry_err, no set_pin.
- Gap drop: A, 1, F, then B pressed during GAP and held through it -> no further event; B must be released and re-pressed to start an entry.
- Reset mid-entry: A, 6, assert rst for 1 cycle, then F -> no set_pin; all outputs 0; FSM in IDLE.
